// File: rtl/check_ram_mp_pkg.sv
// Shared constants for the RAB TLB lookup engine: entry bit layout, FSM states,
// and a constant-foldable clog2.
package check_ram_mp_pkg;

  localparam int unsigned ENT_V       = 0;
  localparam int unsigned ENT_R       = 1;
  localparam int unsigned ENT_W       = 2;
  localparam int unsigned ENT_M       = 3;
  localparam int unsigned ENT_VPN_LSB = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((32'd1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/check_ram_banks.sv
// Banked entry RAM: one synchronous read port per bank (all banks read the same
// {set,offset}) and a single write port whose bank is taken from the address MSBs.
module check_ram_banks #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned BANK_W     = 1,
  parameter int unsigned LOC_AW     = 9,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rd_en_i,
  input  logic [LOC_AW-1:0]                     rd_loc_i,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rd_data_o,
  input  logic                                  we_i,
  input  logic [BANK_W+LOC_AW-1:0]              waddr_i,
  input  logic [DATA_WIDTH-1:0]                 wdata_i
);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [2**LOC_AW];
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (we_i && (waddr_i[BANK_W+LOC_AW-1 -: BANK_W] == BANK_W'(p)))
        mem[waddr_i[LOC_AW-1:0]] <= wdata_i;
      if (rd_en_i)
        rd_q <= mem[rd_loc_i];
    end

    assign rd_data_o[p] = rd_q;
  end

endmodule

// File: rtl/check_ram_mp.sv
// RAB slice-miss TLB lookup: scans one set across NUM_PORTS banks per cycle.
// Define RAB_TLB_MULTIHIT_EN to scan all offsets and count matches across the set.
module check_ram_mp
  import check_ram_mp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned PAGE_SIZE    = 4096,
  parameter int unsigned SET_WIDTH    = 5,
  parameter int unsigned OFFSET_WIDTH = 4,
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] in_addr_i,
  input  logic                  rw_type_i,
  input  logic                  cfg_we_i,
  input  logic [((NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1)+SET_WIDTH+OFFSET_WIDTH-1:0] cfg_addr_i,
  input  logic [DATA_WIDTH-1:0] cfg_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic                  hit_o,
  output logic [((NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1)+SET_WIDTH+OFFSET_WIDTH-1:0] hit_addr_o,
  output logic                  master_o,
  output logic                  prot_o,
  output logic                  multi_hit_o
);

  localparam int unsigned PAGE_LSB = clog2(PAGE_SIZE);
  localparam int unsigned VPN_W    = ADDR_WIDTH - PAGE_LSB;
  localparam int unsigned BANK_W   = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;
  localparam int unsigned LOC_AW   = SET_WIDTH + OFFSET_WIDTH;
  localparam int unsigned RAM_AW   = BANK_W + LOC_AW;

  state_e                  state_q, state_d;
  logic [SET_WIDTH-1:0]    set_q, set_d;
  logic [VPN_W-1:0]        vpn_q, vpn_d;
  logic                    rw_q, rw_d;
  logic [OFFSET_WIDTH:0]   cnt_q, cnt_d;
  logic                    issue;

  logic                    rd_vld_q, rd_vld_d;
  logic [OFFSET_WIDTH-1:0] rd_off_q;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_data;

  logic                    c_hit, c_m, c_r, c_w;
  logic [BANK_W-1:0]       c_bank;
  logic [1:0]              c_nm;

  logic                    cmp_vld_q, cmp_vld_d, cmp_hit_q, cmp_m_q, cmp_r_q, cmp_w_q;
  logic [OFFSET_WIDTH-1:0] cmp_off_q;
  logic [BANK_W-1:0]       cmp_bank_q;
  logic [1:0]              cmp_nm_q;
  logic                    cmp_last;

  logic                    hit_q, hit_d, master_q, master_d, prot_q, prot_d, multi_q, multi_d;
  logic [RAM_AW-1:0]       haddr_q, haddr_d;

  logic                    fin, fin_hit, fin_m, fin_r, fin_w, fin_multi;
  logic [BANK_W-1:0]       fin_bank;
  logic [OFFSET_WIDTH-1:0] fin_off;

`ifdef RAB_TLB_MULTIHIT_EN
  logic                    acc_hit_q, acc_hit_d, acc_m_q, acc_m_d, acc_r_q, acc_r_d, acc_w_q, acc_w_d;
  logic [BANK_W-1:0]       acc_bank_q, acc_bank_d;
  logic [OFFSET_WIDTH-1:0] acc_off_q, acc_off_d;
  logic [1:0]              acc_nm_q, acc_nm_d;
  logic [2:0]              nm_sum;
`endif

  logic unused_bits;
  assign unused_bits = ^{in_addr_i[PAGE_LSB-1:0], rd_data};

  // Write strobes own the cycle: no read is issued and the offset holds.
  assign issue        = (state_q == S_SEARCH) && !cfg_we_i && !cnt_q[OFFSET_WIDTH];
  assign req_ready_o  = rst_ni && (state_q == S_IDLE) && !cfg_we_i;
  assign resp_valid_o = (state_q == S_DONE);
  assign cmp_last     = (cmp_off_q == {OFFSET_WIDTH{1'b1}});
  assign hit_o        = hit_q;
  assign hit_addr_o   = haddr_q;
  assign master_o     = master_q;
  assign prot_o       = prot_q;
  assign multi_hit_o  = multi_q;

  check_ram_banks #(
    .NUM_PORTS (NUM_PORTS),
    .BANK_W    (BANK_W),
    .LOC_AW    (LOC_AW),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_banks (
    .clk_i    (clk_i),
    .rd_en_i  (issue),
    .rd_loc_i ({set_q, cnt_q[OFFSET_WIDTH-1:0]}),
    .rd_data_o(rd_data),
    .we_i     (cfg_we_i),
    .waddr_i  (cfg_addr_i),
    .wdata_i  (cfg_wdata_i)
  );

  // Descending scan so the lowest matching bank is the one left selected.
  always_comb begin
    c_hit  = 1'b0;
    c_bank = '0;
    c_m    = 1'b0;
    c_r    = 1'b0;
    c_w    = 1'b0;
    c_nm   = 2'd0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (rd_data[p][ENT_V] && (rd_data[p][ENT_VPN_LSB +: VPN_W] == vpn_q)) begin
        c_hit  = 1'b1;
        c_bank = BANK_W'(p);
        c_m    = rd_data[p][ENT_M];
        c_r    = rd_data[p][ENT_R];
        c_w    = rd_data[p][ENT_W];
        c_nm   = (c_nm == 2'd0) ? 2'd1 : 2'd2;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    set_d     = set_q;
    vpn_d     = vpn_q;
    rw_d      = rw_q;
    cnt_d     = cnt_q;
    hit_d     = hit_q;
    haddr_d   = haddr_q;
    master_d  = master_q;
    prot_d    = prot_q;
    multi_d   = multi_q;
    fin       = 1'b0;
    fin_hit   = 1'b0;
    fin_bank  = '0;
    fin_off   = '0;
    fin_m     = 1'b0;
    fin_r     = 1'b0;
    fin_w     = 1'b0;
    fin_multi = 1'b0;
`ifdef RAB_TLB_MULTIHIT_EN
    acc_hit_d  = acc_hit_q;
    acc_bank_d = acc_bank_q;
    acc_off_d  = acc_off_q;
    acc_m_d    = acc_m_q;
    acc_r_d    = acc_r_q;
    acc_w_d    = acc_w_q;
    acc_nm_d   = acc_nm_q;
    nm_sum     = 3'd0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          set_d   = in_addr_i[PAGE_LSB +: SET_WIDTH];
          vpn_d   = in_addr_i[ADDR_WIDTH-1:PAGE_LSB];
          rw_d    = rw_type_i;
          cnt_d   = '0;
          state_d = S_SEARCH;
`ifdef RAB_TLB_MULTIHIT_EN
          acc_hit_d = 1'b0;
          acc_nm_d  = 2'd0;
`endif
        end
      end
      S_SEARCH: begin
        if (issue) cnt_d = cnt_q + (OFFSET_WIDTH+1)'(1);
`ifdef RAB_TLB_MULTIHIT_EN
        if (cmp_vld_q) begin
          if (!acc_hit_q && cmp_hit_q) begin
            acc_hit_d  = 1'b1;
            acc_bank_d = cmp_bank_q;
            acc_off_d  = cmp_off_q;
            acc_m_d    = cmp_m_q;
            acc_r_d    = cmp_r_q;
            acc_w_d    = cmp_w_q;
          end
          nm_sum   = {1'b0, acc_nm_q} + {1'b0, cmp_nm_q};
          acc_nm_d = (nm_sum[2] | nm_sum[1]) ? 2'd2 : nm_sum[1:0];
          if (cmp_last) begin
            fin       = 1'b1;
            fin_hit   = acc_hit_d;
            fin_bank  = acc_bank_d;
            fin_off   = acc_off_d;
            fin_m     = acc_m_d;
            fin_r     = acc_r_d;
            fin_w     = acc_w_d;
            fin_multi = acc_nm_d[1];
          end
        end
`else
        if (cmp_vld_q && (cmp_hit_q || cmp_last)) begin
          fin       = 1'b1;
          fin_hit   = cmp_hit_q;
          fin_bank  = cmp_bank_q;
          fin_off   = cmp_off_q;
          fin_m     = cmp_m_q;
          fin_r     = cmp_r_q;
          fin_w     = cmp_w_q;
          fin_multi = cmp_nm_q[1];
        end
`endif
        if (fin) begin
          state_d  = S_DONE;
          hit_d    = fin_hit;
          haddr_d  = fin_hit ? {fin_bank, set_q, fin_off} : '0;
          master_d = fin_hit & fin_m;
          prot_d   = fin_hit && (rw_q ? !fin_w : !fin_r);
          multi_d  = fin_multi;
        end
      end
      S_DONE: if (resp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Anything still in flight when the search ends is dropped.
    rd_vld_d  = issue && (state_d == S_SEARCH);
    cmp_vld_d = rd_vld_q && (state_d == S_SEARCH);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      set_q      <= '0;
      vpn_q      <= '0;
      rw_q       <= 1'b0;
      cnt_q      <= '0;
      rd_vld_q   <= 1'b0;
      rd_off_q   <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_off_q  <= '0;
      cmp_hit_q  <= 1'b0;
      cmp_bank_q <= '0;
      cmp_m_q    <= 1'b0;
      cmp_r_q    <= 1'b0;
      cmp_w_q    <= 1'b0;
      cmp_nm_q   <= 2'd0;
      hit_q      <= 1'b0;
      haddr_q    <= '0;
      master_q   <= 1'b0;
      prot_q     <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      set_q     <= set_d;
      vpn_q     <= vpn_d;
      rw_q      <= rw_d;
      cnt_q     <= cnt_d;
      rd_vld_q  <= rd_vld_d;
      cmp_vld_q <= cmp_vld_d;
      if (issue) rd_off_q <= cnt_q[OFFSET_WIDTH-1:0];
      if (rd_vld_q) begin
        cmp_off_q  <= rd_off_q;
        cmp_hit_q  <= c_hit;
        cmp_bank_q <= c_bank;
        cmp_m_q    <= c_m;
        cmp_r_q    <= c_r;
        cmp_w_q    <= c_w;
        cmp_nm_q   <= c_nm;
      end
      hit_q    <= hit_d;
      haddr_q  <= haddr_d;
      master_q <= master_d;
      prot_q   <= prot_d;
      multi_q  <= multi_d;
    end
  end

`ifdef RAB_TLB_MULTIHIT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_hit_q  <= 1'b0;
      acc_bank_q <= '0;
      acc_off_q  <= '0;
      acc_m_q    <= 1'b0;
      acc_r_q    <= 1'b0;
      acc_w_q    <= 1'b0;
      acc_nm_q   <= 2'd0;
    end else begin
      acc_hit_q  <= acc_hit_d;
      acc_bank_q <= acc_bank_d;
      acc_off_q  <= acc_off_d;
      acc_m_q    <= acc_m_d;
      acc_r_q    <= acc_r_d;
      acc_w_q    <= acc_w_d;
      acc_nm_q   <= acc_nm_d;
    end
  end
`endif

endmodule

// File: tb/tb_check_ram_mp.sv
// Randomised bench for check_ram_mp (default parameters) against an array-based
// model of the lookup rules; covers both early-stop and full-scan builds.
module tb_check_ram_mp;

  logic        clk, rst_n;
  logic        req_valid, req_ready, rw_type, cfg_we;
  logic        resp_valid, resp_ready, hit, master, prot, multi;
  logic [31:0] in_addr, cfg_wdata;
  logic [9:0]  cfg_addr, hit_addr;

  logic [31:0] mdl [1024];
  int          total = 0;
  int          bad   = 0;

  check_ram_mp dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .in_addr_i   (in_addr),
    .rw_type_i   (rw_type),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .hit_o       (hit),
    .hit_addr_o  (hit_addr),
    .master_o    (master),
    .prot_o      (prot),
    .multi_hit_o (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cfg_wr(input int a, input logic [31:0] d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = 10'(a);
    cfg_wdata = d;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    mdl[a] = d;
  endtask

  // Reference: walk the set offset by offset, banks low to high.
  task automatic model(input logic [31:0] a, input bit rw, output bit e_hit, output int e_addr,
                       output bit e_m, output bit e_p, output bit e_mh, output int last);
    logic [19:0] vpn;
    int set, first, same, tot;
    bit r, w;
    vpn = a[31:12];
    set = int'(a[16:12]);
    e_hit = 0; e_addr = 0; e_m = 0; r = 0; w = 0;
    first = -1; same = 0; tot = 0;
    for (int off = 0; off < 16; off++) begin
      int n;
      n = 0;
      for (int b = 0; b < 2; b++) begin
        logic [31:0] e;
        e = mdl[b*512 + set*16 + off];
        if (e[0] && e[23:4] == vpn) begin
          n++; tot++;
          if (!e_hit) begin
            e_hit = 1; e_addr = b*512 + set*16 + off;
            e_m = e[3]; r = e[1]; w = e[2];
          end
        end
      end
      if (n > 0 && first < 0) begin first = off; same = n; end
    end
`ifdef RAB_TLB_MULTIHIT_EN
    last = 15;
    e_mh = (tot >= 2);
`else
    last = e_hit ? first : 15;
    e_mh = (same >= 2);
`endif
    e_p = e_hit && (rw ? !w : !r);
  endtask

  task automatic lookup(input logic [31:0] a, input bit rw, input int s, input int len, input int bp,
                        input int sa, input logic [31:0] sd);
    bit e_hit, e_m, e_p, e_mh, seen;
    int e_addr, last, e_lat, cyc;
    model(a, rw, e_hit, e_addr, e_m, e_p, e_mh, last);
    e_lat = last + 3 + ((len > 0 && s <= last) ? len : 0);
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; in_addr = a; rw_type = rw; resp_ready = 1'b0;
    @(posedge clk);
    cyc = 0; seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) seen = 1;
      else begin
        if (len > 0 && cyc >= s && cyc < s + len) begin
          cfg_we = 1'b1; cfg_addr = 10'(sa); cfg_wdata = sd; mdl[sa] = sd;
        end else cfg_we = 1'b0;
        @(posedge clk);
        cyc++;
      end
    end
    cfg_we = 1'b0;
    chk("latency", 32'(cyc), 32'(e_lat));
    chk("hit", 32'(hit), 32'(e_hit));
    chk("hit_addr", 32'(hit_addr), 32'(e_addr));
    chk("master", 32'(master), 32'(e_m));
    chk("prot", 32'(prot), 32'(e_p));
    chk("multi_hit", 32'(multi), 32'(e_mh));
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold", 32'({resp_valid, req_ready, hit, master, prot, multi, hit_addr}),
          32'({1'b1, 1'b0, e_hit, e_m, e_p, e_mh, 10'(e_addr)}));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("idle", 32'({resp_valid, req_ready, hit, hit_addr}), 32'({1'b0, 1'b1, e_hit, 10'(e_addr)}));
  endtask

  int pool [4] = '{2, 7, 18, 25};

  initial begin
    bit got_resp;
    rst_n = 1'b1; req_valid = 0; rw_type = 0; cfg_we = 0; resp_ready = 0;
    in_addr = 0; cfg_addr = 0; cfg_wdata = 0;
    #1 rst_n = 1'b0;
    #2 chk("por_outs", 32'({resp_valid, req_ready, hit, master, prot, multi, hit_addr}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("por_ready", 32'(req_ready), 32'd1);
    @(negedge clk) cfg_we = 1'b1;
    #1 chk("ready_we", 32'(req_ready), 32'd0);
    cfg_we = 1'b0;

    for (int i = 0; i < 1024; i++) cfg_wr(i, 32'd0);

    cfg_wr(32'h123, 32'h12B);
    lookup(32'h0001_2345, 0, 0, 0, 0, 0, 0);
    lookup(32'h0001_2345, 1, 0, 0, 0, 0, 0);
`ifdef RAB_TLB_MULTIHIT_EN
    cfg_wr(32'h129, 32'h12B);
`else
    cfg_wr(32'h323, 32'h12B);
`endif
    lookup(32'h0001_2345, 0, 0, 0, 0, 0, 0);
    lookup(32'h0000_5000, 0, 0, 0, 0, 0, 0);
    lookup(32'h0001_2345, 0, 1, 2, 5, 32'h133, 32'h0);

    // Abort a search with reset part-way through.
    @(negedge clk);
    req_valid = 1'b1; in_addr = 32'h0001_2345; rw_type = 1'b0;
    @(posedge clk);
    @(negedge clk) req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_outs", 32'({resp_valid, req_ready, hit, master, prot, multi, hit_addr}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_ready", 32'(req_ready), 32'd1);
    got_resp = 0;
    repeat (25) begin
      @(negedge clk);
      if (resp_valid) got_resp = 1;
    end
    chk("rst_noresp", 32'(got_resp), 32'd0);

    for (int t = 0; t < 40; t++) begin
      logic [4:0]  st;
      logic [31:0] d, a;
      int sa;
      repeat (3) begin
        st = 5'(pool[$urandom_range(0, 3)]);
        d = $urandom;
        d[0] = ($urandom_range(0, 3) != 0);
        d[23:4] = {15'($urandom_range(0, 2)), st};
        cfg_wr(int'({1'($urandom_range(0, 1)), st, 4'($urandom_range(0, 15))}), d);
      end
      st = 5'(pool[$urandom_range(0, 3)]);
      a = {15'($urandom_range(0, 2)), st, 12'($urandom)};
      sa = int'({1'($urandom_range(0, 1)), st ^ 5'd1, 4'($urandom_range(0, 15))});
      lookup(a, 1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom_range(0, 3),
             $urandom_range(0, 3), sa, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
